rf_writeback_ctrl: RTL and testbench

//   Write-side controller for the rv32i register file. Merges ALU results and
//   out-of-order load returns into the file's single write port, and arbitrates

---
 rtl/rf_writeback_ctrl.sv | 142 ++++++++++++++
 tb/tb_rf_writeback_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_writeback_ctrl.sv
// Write-side controller for the rv32i register file: arbitrates load returns,
// a one-entry hold buffer and ALU results onto the single write port, tracks pending loads, bypasses operands.
module rf_writeback_ctrl #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            ld_issue,
    input  logic [AW-1:0]   ld_issue_rd,
    input  logic            ld_valid,
    input  logic [AW-1:0]   ld_rd,
    input  logic [XLEN-1:0] ld_data,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    input  logic [AW-1:0]   chk_rd,
    input  logic [XLEN-1:0] rf_op_a,
    input  logic [XLEN-1:0] rf_op_b,
    output logic [XLEN-1:0] op_a,
    output logic [XLEN-1:0] op_b,
    output logic            hazard,
    output logic            rf_we,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata
);

    localparam int unsigned NREG = 2 ** AW;

    logic [NREG-1:0] pend_q, pend_d;
    logic            hold_full_q, hold_full_d;
    logic [AW-1:0]   hold_rd_q, hold_rd_d;
    logic [XLEN-1:0] hold_data_q, hold_data_d;
    logic            we_q, we_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;

    logic alu_take;
    logic ld_take;

    assign alu_ready = !hold_full_q;
    // Writes to x0 are dropped outright; they neither win the port nor enter hold.
    assign alu_take  = alu_valid && !hold_full_q && (alu_rd != '0);
    assign ld_take   = ld_valid && (ld_rd != '0);

    always_comb begin
        we_d        = 1'b0;
        waddr_d     = '0;
        wdata_d     = '0;
        hold_full_d = hold_full_q;
        hold_rd_d   = hold_rd_q;
        hold_data_d = hold_data_q;

        if (ld_take) begin
            we_d    = 1'b1;
            waddr_d = ld_rd;
            wdata_d = ld_data;
            if (alu_take) begin
                hold_full_d = 1'b1;
                hold_rd_d   = alu_rd;
                hold_data_d = alu_data;
            end
        end else if (hold_full_q) begin
            we_d        = 1'b1;
            waddr_d     = hold_rd_q;
            wdata_d     = hold_data_q;
            hold_full_d = alu_take;
            if (alu_take) begin
                hold_rd_d   = alu_rd;
                hold_data_d = alu_data;
            end
        end else if (alu_take) begin
            we_d    = 1'b1;
            waddr_d = alu_rd;
            wdata_d = alu_data;
        end
    end

    // Clear before set so a same-cycle reissue to the returning register stays pending.
    always_comb begin
        pend_d = pend_q;
        if (ld_valid) begin
            pend_d[ld_rd] = 1'b0;
        end
        if (ld_issue) begin
            pend_d[ld_issue_rd] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    assign hazard = pend_q[rs1_addr] | pend_q[rs2_addr] | pend_q[chk_rd];

    always_comb begin
        op_a = rf_op_a;
        if (rs1_addr == '0) begin
            op_a = '0;
        end else if (we_q && (waddr_q == rs1_addr)) begin
            op_a = wdata_q;
        end else if (hold_full_q && (hold_rd_q == rs1_addr)) begin
            op_a = hold_data_q;
        end
    end

    always_comb begin
        op_b = rf_op_b;
        if (rs2_addr == '0) begin
            op_b = '0;
        end else if (we_q && (waddr_q == rs2_addr)) begin
            op_b = wdata_q;
        end else if (hold_full_q && (hold_rd_q == rs2_addr)) begin
            op_b = hold_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q      <= '0;
            hold_full_q <= 1'b0;
            hold_rd_q   <= '0;
            hold_data_q <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
        end else begin
            pend_q      <= pend_d;
            hold_full_q <= hold_full_d;
            hold_rd_q   <= hold_rd_d;
            hold_data_q <= hold_data_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign rf_we    = we_q;
    assign rf_waddr = waddr_q;
    assign rf_wdata = wdata_q;

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Bench for rf_writeback_ctrl: directed scenarios then random traffic, all
// outputs compared each cycle against a queue-based write-port reference model.
module tb_rf_writeback_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_issue;
    logic [4:0]  ld_issue_rd;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic [4:0]  rs1_addr, rs2_addr, chk_rd;
    logic [31:0] rf_op_a, rf_op_b;
    logic [31:0] op_a, op_b;
    logic        hazard;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    always #5 clk = ~clk;

    rf_writeback_ctrl #(.XLEN(32), .AW(5)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .chk_rd(chk_rd),
        .rf_op_a(rf_op_a), .rf_op_b(rf_op_b), .op_a(op_a), .op_b(op_b),
        .hazard(hazard), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    // Bench-side register array; x0 reads garbage so the zero forcing is visible.
    logic [31:0] rf_arr [32];
    assign rf_op_a = (rs1_addr == 5'd0) ? 32'hDEAD_BEEF : rf_arr[rs1_addr];
    assign rf_op_b = (rs2_addr == 5'd0) ? 32'hDEAD_BEEF : rf_arr[rs2_addr];

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] d;
    } wr_t;

    wr_t         m_hold[$];
    logic [31:0] m_pend;
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic [4:0]  outst[$];

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] exp_op(input logic [4:0] rs, input logic [31:0] raw);
        if (rs == 5'd0) return 32'd0;
        if (m_we && m_waddr == rs) return m_wdata;
        if (m_hold.size() > 0 && m_hold[0].rd == rs) return m_hold[0].d;
        return raw;
    endfunction

    // Ordered candidate list: first entry takes the port, the leftover (if any) is held.
    task automatic model_update();
        wr_t cand[$];
        bit  acc;
        if (m_we) rf_arr[m_waddr] = m_wdata;
        if (rst) begin
            m_hold.delete();
            outst.delete();
            m_pend  = '0;
            m_we    = 1'b0;
            m_waddr = '0;
            m_wdata = '0;
            return;
        end
        acc = alu_valid && (m_hold.size() == 0);
        if (ld_valid && ld_rd != 5'd0) cand.push_back('{ld_rd, ld_data});
        if (m_hold.size() > 0) cand.push_back(m_hold.pop_front());
        if (acc && alu_rd != 5'd0) cand.push_back('{alu_rd, alu_data});
        if (cand.size() > 0) begin
            wr_t w;
            w = cand.pop_front();
            m_we = 1'b1; m_waddr = w.rd; m_wdata = w.d;
        end else begin
            m_we = 1'b0; m_waddr = '0; m_wdata = '0;
        end
        m_hold = cand;
        if (ld_valid) m_pend[ld_rd] = 1'b0;
        if (ld_issue && ld_issue_rd != 5'd0) m_pend[ld_issue_rd] = 1'b1;
    endtask

    task automatic step();
        @(negedge clk);
        check_eq("alu_ready", {31'd0, alu_ready}, {31'd0, m_hold.size() == 0});
        check_eq("hazard", {31'd0, hazard}, {31'd0, m_pend[rs1_addr] | m_pend[rs2_addr] | m_pend[chk_rd]});
        check_eq("op_a", op_a, exp_op(rs1_addr, rf_op_a));
        check_eq("op_b", op_b, exp_op(rs2_addr, rf_op_b));
        check_eq("rf_we", {31'd0, rf_we}, {31'd0, m_we});
        check_eq("rf_waddr", {27'd0, rf_waddr}, {27'd0, m_waddr});
        check_eq("rf_wdata", rf_wdata, m_wdata);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_issue = 1'b0; ld_issue_rd = '0; ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
        rs1_addr = '0; rs2_addr = '0; chk_rd = '0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_arr[i] = '0;
        m_pend = '0; m_we = 1'b0; m_waddr = '0; m_wdata = '0;
        idle();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        model_update();
        #1;
        rst = 1'b0;
        check_eq("rst_we", {31'd0, rf_we}, 32'd0);
        check_eq("rst_waddr", {27'd0, rf_waddr}, 32'd0);
        check_eq("rst_wdata", rf_wdata, 32'd0);
        check_eq("rst_ready", {31'd0, alu_ready}, 32'd1);

        // ALU write reaches the port one cycle later
        idle(); alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h11;
        step();
        idle(); #1;
        check_eq("t1_we", {31'd0, rf_we}, 32'd1);
        check_eq("t1_waddr", {27'd0, rf_waddr}, 32'd5);
        check_eq("t1_wdata", rf_wdata, 32'h11);
        check_eq("t1_ready", {31'd0, alu_ready}, 32'd1);
        step();

        // Load beats ALU; ALU result waits one cycle in hold
        idle(); ld_valid = 1'b1; ld_rd = 5'd6; ld_data = 32'hAA;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hBB;
        step();
        idle(); #1;
        check_eq("t2_waddr_ld", {27'd0, rf_waddr}, 32'd6);
        check_eq("t2_wdata_ld", rf_wdata, 32'hAA);
        check_eq("t2_ready_lo", {31'd0, alu_ready}, 32'd0);
        step();
        check_eq("t2_waddr_alu", {27'd0, rf_waddr}, 32'd7);
        check_eq("t2_wdata_alu", rf_wdata, 32'hBB);
        check_eq("t2_ready_hi", {31'd0, alu_ready}, 32'd1);
        step();

        // Pending load on x9 raises hazard until its return is registered
        idle(); ld_issue = 1'b1; ld_issue_rd = 5'd9;
        step();
        idle(); rs1_addr = 5'd9; #1;
        check_eq("t3_haz_issued", {31'd0, hazard}, 32'd1);
        step();
        step();
        idle(); rs1_addr = 5'd9; ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h99; #1;
        check_eq("t3_haz_return", {31'd0, hazard}, 32'd1);
        step();
        idle(); rs1_addr = 5'd9; #1;
        check_eq("t3_haz_clear", {31'd0, hazard}, 32'd0);
        step();

        // In-flight write bypassed over a stale file read
        idle(); alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h1234; rs2_addr = 5'd3;
        step();
        idle(); rs2_addr = 5'd3; #1;
        check_eq("t4_rf_stale", rf_op_b, 32'd0);
        check_eq("t4_op_b", op_b, 32'h1234);
        step();

        // x0 writes are dropped; x0 reads are zero
        idle(); alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF;
        step();
        idle(); #1;
        check_eq("t5_we", {31'd0, rf_we}, 32'd0);
        check_eq("t5_op_a", op_a, 32'd0);
        step();

        // Reset while hold is full discards hold and pending bits
        idle(); ld_issue = 1'b1; ld_issue_rd = 5'd12;
        step();
        idle(); ld_valid = 1'b1; ld_rd = 5'd10; ld_data = 32'h1010;
        alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'h1111;
        step();
        idle(); #1;
        check_eq("t6_hold_full", {31'd0, alu_ready}, 32'd0);
        rst = 1'b1;
        step();
        idle(); rs1_addr = 5'd12; #1;
        check_eq("t6_we", {31'd0, rf_we}, 32'd0);
        check_eq("t6_ready", {31'd0, alu_ready}, 32'd1);
        check_eq("t6_hazard", {31'd0, hazard}, 32'd0);
        step();
        idle(); #1;
        check_eq("t6_no_write", {31'd0, rf_we}, 32'd0);
        step();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            logic [4:0] r;
            idle();
            rst = ($urandom_range(0, 199) == 0);
            alu_valid = ($urandom_range(0, 1) == 1);
            r = 5'($urandom_range(0, 31));
            for (int t = 0; t < 8 && m_pend[r]; t++) r = 5'($urandom_range(0, 31));
            if (m_pend[r]) alu_valid = 1'b0;
            alu_rd = r;
            alu_data = $urandom;
            ld_data = $urandom;
            if (outst.size() > 0 && $urandom_range(0, 2) == 0) begin
                int idx;
                idx = $urandom_range(0, outst.size() - 1);
                ld_valid = 1'b1;
                ld_rd = outst[idx];
                outst.delete(idx);
            end else if ($urandom_range(0, 49) == 0) begin
                ld_valid = 1'b1;
                ld_rd = 5'($urandom_range(1, 31));
            end
            if ($urandom_range(0, 3) == 0) begin
                r = 5'($urandom_range(1, 31));
                if (!m_pend[r] || (ld_valid && ld_rd == r)) begin
                    ld_issue = 1'b1;
                    ld_issue_rd = r;
                    outst.push_back(r);
                end
            end
            rs1_addr = 5'($urandom_range(0, 31));
            rs2_addr = 5'($urandom_range(0, 31));
            chk_rd   = 5'($urandom_range(0, 31));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
